// File: rtl/button_event_queue_pkg.sv
// ----------------------------------------------------------------------------
// button_event_queue_pkg
//   Shared definitions for the button event queue: the clog2 helper, the
//   event id width, the FIFO entry width and the arbitration source count.
//   Optional feature macro: BUTTON_LONGPRESS_EN (undefined by default). When
//   defined, every button also owns a long-press source, and a FIFO entry
//   carries {long, id} instead of id alone.
// ----------------------------------------------------------------------------
package button_event_queue_pkg;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r = r + 1;
        return r;
    endfunction

    // Button index width; at least one bit even for a single button.
    function automatic int id_width(input int n);
        return (clog2(n) < 1) ? 1 : clog2(n);
    endfunction

    function automatic int entry_width(input int n_buttons);
`ifdef BUTTON_LONGPRESS_EN
        return id_width(n_buttons) + 1;
`else
        return id_width(n_buttons);
`endif
    endfunction

    // Request sources: short i = i, long i = n_buttons + i.
    function automatic int n_sources(input int n_buttons);
`ifdef BUTTON_LONGPRESS_EN
        return 2 * n_buttons;
`else
        return n_buttons;
`endif
    endfunction

endpackage

// File: rtl/button_debounce.sv
// ----------------------------------------------------------------------------
// button_debounce
//   One button: saturating stability counter, debounced level, one-cycle
//   press pulse and, with BUTTON_LONGPRESS_EN defined, a hold timer that
//   fires a single long-press pulse per press.
// Ports
//   clock, reset   system clock, synchronous active-high reset
//   btn_i          raw (already synchronised) button level
//   level_o        debounced level (counter saturated)
//   press_o        one-cycle pulse on a debounced rising level
//   long_o         one-cycle long-press pulse (constant 0 without the macro)
// ----------------------------------------------------------------------------
module button_debounce
    import button_event_queue_pkg::*;
#(
    parameter int DEBOUNCE_BITS = 2,
    parameter int LONG_CYCLES   = 1000
) (
    input  logic clock,
    input  logic reset,
    input  logic btn_i,
    output logic level_o,
    output logic press_o,
    output logic long_o
);

    logic [DEBOUNCE_BITS-1:0] cnt_q, cnt_d;
    logic                     level_q;
    logic                     armed_q, armed_d;

    always_comb begin
        cnt_d = '0;
        if (btn_i) cnt_d = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
    end

    // A button held through reset stays disarmed until it is seen released,
    // so a held button never produces an event just because reset ended.
    assign armed_d = armed_q | ~btn_i;

    assign level_o = &cnt_q;
    assign press_o = level_o & ~level_q & armed_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q   <= '0;
            level_q <= 1'b0;
            armed_q <= ~btn_i;
        end else begin
            cnt_q   <= cnt_d;
            level_q <= level_o;
            armed_q <= armed_d;
        end
    end

`ifdef BUTTON_LONGPRESS_EN
    localparam int HW = clog2(LONG_CYCLES + 1);
    localparam logic [HW-1:0] HOLD_SAT  = HW'(LONG_CYCLES);
    localparam logic [HW-1:0] HOLD_FIRE = HW'(LONG_CYCLES - 1);

    logic [HW-1:0] hold_q, hold_d;

    // Saturating above the fire value guarantees one long pulse per press.
    always_comb begin
        hold_d = '0;
        if (level_o) hold_d = (hold_q == HOLD_SAT) ? hold_q : hold_q + 1'b1;
    end

    assign long_o = level_o & armed_q & (hold_q == HOLD_FIRE);

    always_ff @(posedge clock) begin
        if (reset) hold_q <= '0;
        else       hold_q <= hold_d;
    end
`else
    // No hold timer; the expression folds to constant 0.
    assign long_o = (LONG_CYCLES < 0);
`endif

endmodule

// File: rtl/button_event_queue.sv
// ----------------------------------------------------------------------------
// button_event_queue
//   Debounces N_BUTTONS buttons, latches each press as a pending request,
//   serialises requests through a round-robin arbiter into a small FIFO and
//   presents the FIFO head on a valid/ready stream.
//   Optional feature macro: BUTTON_LONGPRESS_EN (undefined by default) adds a
//   long-press source per button and the evt_long_o flag.
// Ports
//   clock, reset   system clock, synchronous active-high reset
//   btn_in_i       raw button levels, synchronised to clock
//   evt_valid_o    FIFO head holds an event
//   evt_ready_i    consumer accepts the head when valid & ready
//   evt_id_o       button index of the head event (0 when empty)
//   evt_long_o     head event is a long press
//   dropped_o      sticky: an event merged into an already-pending request
//   clr_drop_i     clears dropped_o; a simultaneous drop wins
//   level_o        debounced button levels
// ----------------------------------------------------------------------------
module button_event_queue
    import button_event_queue_pkg::*;
#(
    parameter int N_BUTTONS     = 5,
    parameter int DEBOUNCE_BITS = 2,
    parameter int FIFO_DEPTH    = 4,
    parameter int LONG_CYCLES   = 1000
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic [N_BUTTONS-1:0]           btn_in_i,
    output logic                           evt_valid_o,
    input  logic                           evt_ready_i,
    output logic [id_width(N_BUTTONS)-1:0] evt_id_o,
    output logic                           evt_long_o,
    output logic                           dropped_o,
    input  logic                           clr_drop_i,
    output logic [N_BUTTONS-1:0]           level_o
);

    localparam int IDW  = id_width(N_BUTTONS);
    localparam int EW   = entry_width(N_BUTTONS);
    localparam int NSRC = n_sources(N_BUTTONS);
    localparam int SW   = id_width(NSRC);
    localparam int PW   = clog2(FIFO_DEPTH);
    localparam int CW   = PW + 1;

    // ---------------- per-button debounce ----------------
    logic [N_BUTTONS-1:0] press, long_ev;

    for (genvar g = 0; g < N_BUTTONS; g++) begin : g_btn
        button_debounce #(
            .DEBOUNCE_BITS (DEBOUNCE_BITS),
            .LONG_CYCLES   (LONG_CYCLES)
        ) u_db (
            .clock   (clock),
            .reset   (reset),
            .btn_i   (btn_in_i[g]),
            .level_o (level_o[g]),
            .press_o (press[g]),
            .long_o  (long_ev[g])
        );
    end

    logic [NSRC-1:0] evt_src;
`ifdef BUTTON_LONGPRESS_EN
    assign evt_src = {long_ev, press};
`else
    logic unused_long;
    assign evt_src     = press;
    assign unused_long = ^long_ev;
`endif

    // ---------------- state ----------------
    logic [NSRC-1:0] pend_q, pend_d;
    logic [SW-1:0]   rr_q, rr_d;
    logic            dropped_q, dropped_d;
    logic [PW-1:0]   wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [EW-1:0]   mem_q [FIFO_DEPTH];

    // ---------------- round-robin arbiter ----------------
    logic            full;
    logic            gnt_vld;
    logic [SW-1:0]   gnt_idx;
    logic [NSRC-1:0] gnt_vec;

    assign full = (cnt_q == CW'(FIFO_DEPTH));

    // Grant is gated by full at cycle start, so a pop in the same cycle
    // never makes room for a push.
    always_comb begin
        int idx;
        gnt_vld = 1'b0;
        gnt_idx = '0;
        idx     = 0;
        for (int k = 0; k < NSRC; k++) begin
            idx = int'(rr_q) + k;
            if (idx >= NSRC) idx = idx - NSRC;
            if (!full && !gnt_vld && pend_q[SW'(idx)]) begin
                gnt_vld = 1'b1;
                gnt_idx = SW'(idx);
            end
        end
    end

    assign gnt_vec = gnt_vld ? (NSRC'(1) << gnt_idx) : '0;

    always_comb begin
        rr_d = rr_q;
        if (gnt_vld) rr_d = (int'(gnt_idx) == NSRC - 1) ? '0 : gnt_idx + SW'(1);
    end

    // A new event on the source being granted re-arms it without a drop.
    assign pend_d    = (pend_q & ~gnt_vec) | evt_src;
    assign dropped_d = (|(evt_src & pend_q & ~gnt_vec)) | (dropped_q & ~clr_drop_i);

    // ---------------- FIFO ----------------
    logic [EW-1:0] wr_entry, head;
    logic          push, pop;

`ifdef BUTTON_LONGPRESS_EN
    always_comb begin
        if (int'(gnt_idx) >= N_BUTTONS) wr_entry = {1'b1, IDW'(int'(gnt_idx) - N_BUTTONS)};
        else                            wr_entry = {1'b0, IDW'(gnt_idx)};
    end
`else
    assign wr_entry = EW'(gnt_idx);
`endif

    assign push = gnt_vld;
    assign pop  = evt_valid_o & evt_ready_i;
    assign head = mem_q[rd_q];

    assign wr_d  = push ? wr_q + PW'(1) : wr_q;
    assign rd_d  = pop  ? rd_q + PW'(1) : rd_q;
    assign cnt_d = cnt_q + CW'(push) - CW'(pop);

    always_ff @(posedge clock) begin
        if (push) mem_q[wr_q] <= wr_entry;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pend_q    <= '0;
            rr_q      <= '0;
            dropped_q <= 1'b0;
            wr_q      <= '0;
            rd_q      <= '0;
            cnt_q     <= '0;
        end else begin
            pend_q    <= pend_d;
            rr_q      <= rr_d;
            dropped_q <= dropped_d;
            wr_q      <= wr_d;
            rd_q      <= rd_d;
            cnt_q     <= cnt_d;
        end
    end

    // ---------------- outputs ----------------
    assign evt_valid_o = (cnt_q != '0);
    assign evt_id_o    = evt_valid_o ? head[IDW-1:0] : '0;
    assign dropped_o   = dropped_q;
`ifdef BUTTON_LONGPRESS_EN
    assign evt_long_o  = evt_valid_o & head[EW-1];
`else
    assign evt_long_o  = 1'b0;
`endif

endmodule

// File: tb/tb_button_event_queue.sv
// ----------------------------------------------------------------------------
// tb_button_event_queue
//   Directed scenarios plus randomized button/ready/clear/reset traffic for
//   button_event_queue. A queue-based reference model tracks debounce run
//   lengths, pending requests, the round-robin pointer and FIFO contents;
//   outputs are compared against it every cycle on the falling edge.
// ----------------------------------------------------------------------------
module tb_button_event_queue;

    localparam int N       = 5;
    localparam int DB      = 2;
    localparam int DEPTH   = 4;
    localparam int LC      = 20;
    localparam int IDW     = 3;
    localparam int LVL_RUN = (1 << DB) - 1;   // high samples needed for level
`ifdef BUTTON_LONGPRESS_EN
    localparam int NS = 2 * N;
`else
    localparam int NS = N;
`endif

    logic           clock = 1'b0;
    logic           reset = 1'b1;
    logic [N-1:0]   btn   = '0;
    logic           ready = 1'b0;
    logic           clr   = 1'b0;
    logic           evt_valid, evt_long, dropped;
    logic [IDW-1:0] evt_id;
    logic [N-1:0]   level;

    always #5 clock = ~clock;

    button_event_queue #(
        .N_BUTTONS     (N),
        .DEBOUNCE_BITS (DB),
        .FIFO_DEPTH    (DEPTH),
        .LONG_CYCLES   (LC)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .btn_in_i    (btn),
        .evt_valid_o (evt_valid),
        .evt_ready_i (ready),
        .evt_id_o    (evt_id),
        .evt_long_o  (evt_long),
        .dropped_o   (dropped),
        .clr_drop_i  (clr),
        .level_o     (level)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Events are coded as id + 256*long.
    int run   [N];
    int hold  [N];
    bit prevl [N];
    bit armed [N];
    bit pend  [NS];
    int rr;
    int fq[$];
    bit mdrop;
    bit mon_en = 1'b0;
    int popped[$];

    function automatic bit mlevel(input int i);
        return run[i] >= LVL_RUN;
    endfunction

    task automatic model_step();
        bit ev [NS];
        bit lv [N];
        bit drop;
        int g;
        if (reset) begin
            for (int i = 0; i < N; i++) begin
                run[i] = 0; hold[i] = 0; prevl[i] = 0; armed[i] = !btn[i];
            end
            for (int j = 0; j < NS; j++) pend[j] = 0;
            rr = 0; fq.delete(); mdrop = 0;
            return;
        end
        for (int j = 0; j < NS; j++) ev[j] = 0;
        for (int i = 0; i < N; i++) begin
            lv[i] = mlevel(i);
            ev[i] = lv[i] && !prevl[i] && armed[i];
`ifdef BUTTON_LONGPRESS_EN
            ev[N+i] = lv[i] && (hold[i] == LC - 1) && armed[i];
`endif
        end
        g = -1;
        if (fq.size() < DEPTH)
            for (int k = 0; k < NS; k++)
                if (g < 0 && pend[(rr + k) % NS]) g = (rr + k) % NS;
        if (fq.size() > 0 && ready) void'(fq.pop_front());
        if (g >= 0) begin
            fq.push_back(g >= N ? 256 + g - N : g);
            rr = (g + 1) % NS;
        end
        drop = 0;
        for (int j = 0; j < NS; j++) begin
            if (ev[j] && pend[j] && j != g) drop = 1;
            pend[j] = (pend[j] && j != g) || ev[j];
        end
        mdrop = drop || (mdrop && !clr);
        for (int i = 0; i < N; i++) begin
            if (!btn[i]) armed[i] = 1;
            hold[i]  = lv[i] ? ((hold[i] < LC) ? hold[i] + 1 : hold[i]) : 0;
            run[i]   = btn[i] ? ((run[i] < 1000) ? run[i] + 1 : run[i]) : 0;
            prevl[i] = lv[i];
        end
    endtask

    // One clock: model and DUT both advance on the same edge with the same
    // inputs; callers change inputs only after this returns.
    task automatic tick();
        @(posedge clock);
        model_step();
        #1;
    endtask

    // ---------------- per-cycle compare ----------------
    always @(negedge clock) begin
        if (mon_en) begin : cmp_blk
            logic [N-1:0] el;
            el = '0;
            for (int i = 0; i < N; i++) el[i] = mlevel(i);
            chk("evt_valid", int'(evt_valid), int'(fq.size() != 0));
            if (fq.size() != 0) begin
                chk("evt_id", int'(evt_id), fq[0] % 256);
                chk("evt_long", int'(evt_long), int'(fq[0] >= 256));
            end
            chk("level", int'(level), int'(el));
            chk("dropped", int'(dropped), int'(mdrop));
            if (evt_valid && ready) popped.push_back(int'(evt_id) + (evt_long ? 256 : 0));
        end
    end

    task automatic do_reset();
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
    endtask

    task automatic press(input int i);
        btn[i] = 1'b1;
        repeat (4) tick();
        btn[i] = 1'b0;
        tick();
    endtask

    task automatic chk_popped(input string name, input int exp[$]);
        chk({name, "_count"}, popped.size(), exp.size());
        if (popped.size() == exp.size())
            for (int k = 0; k < exp.size(); k++) chk(name, popped[k], exp[k]);
    endtask

    initial begin
        int bounce[5] = '{1, 0, 1, 0, 1};
        tick(); mon_en = 1'b1; tick();
        reset = 1'b0;

        // Reset state
        chk("rst_valid", int'(evt_valid), 0);
        chk("rst_id", int'(evt_id), 0);
        chk("rst_long", int'(evt_long), 0);
        chk("rst_dropped", int'(dropped), 0);
        chk("rst_level", int'(level), 0);

        // Single press latency on button 2
        ready = 1'b1; popped.delete();
        btn = 5'b00100;
        for (int c = 1; c <= 10; c++) begin
            tick();
            if (c == 2) chk("lat_level2_c2", int'(level[2]), 0);
            if (c == 3) chk("lat_level2_c3", int'(level[2]), 1);
            if (c == 4) chk("lat_valid_c4", int'(evt_valid), 0);
            if (c == 5) begin
                chk("lat_valid_c5", int'(evt_valid), 1);
                chk("lat_id_c5", int'(evt_id), 2);
            end
        end
        btn = '0; repeat (4) tick();
        chk_popped("single", '{2});

        // Bounce on button 0 then hold
        popped.delete();
        for (int k = 0; k < 5; k++) begin
            btn[0] = bounce[k][0];
            tick();
            chk("bounce_no_level", int'(level[0]), 0);
        end
        repeat (6) tick();
        btn = '0; repeat (4) tick();
        chk_popped("bounce", '{0});

        // Simultaneous presses from rr_ptr = 0
        do_reset(); ready = 1'b1; popped.delete();
        btn = 5'b11010; repeat (8) tick();
        btn = '0; repeat (2) tick();
        chk_popped("simul", '{1, 3, 4});
        btn = 5'b10010; repeat (8) tick();
        btn = '0; repeat (2) tick();
        chk("simul2_count", popped.size(), 5);

        // Backpressure: FIFO full, overflow waits in pending
        do_reset(); ready = 1'b0;
        for (int i = 0; i < N; i++) press(i);
        press(0);
        chk("bp_valid", int'(evt_valid), 1);
        chk("bp_dropped", int'(dropped), 0);
        ready = 1'b1; popped.delete();
        repeat (10) tick();
        chk_popped("bp_drain", '{0, 1, 2, 3, 4, 0});
        chk("bp_dropped_end", int'(dropped), 0);

        // Merge into a pending request sets dropped; clr_drop clears it
        do_reset(); ready = 1'b0;
        for (int i = 0; i < N; i++) press(i);
        press(0); press(0);
        chk("drop_set", int'(dropped), 1);
        ready = 1'b1; popped.delete();
        repeat (10) tick();
        chk_popped("drop_drain", '{0, 1, 2, 3, 4, 0});
        clr = 1'b1; tick(); clr = 1'b0;
        chk("drop_clr", int'(dropped), 0);

        // Reset mid-operation with button 1 held through it
        do_reset(); ready = 1'b0;
        press(2); press(3);
        btn[1] = 1'b1; repeat (5) tick();
        reset = 1'b1; tick();
        chk("midrst_valid", int'(evt_valid), 0);
        tick(); reset = 1'b0;
        repeat (10) tick();
        chk("held_level", int'(level[1]), 1);
        chk("held_no_evt", int'(evt_valid), 0);
        btn[1] = 1'b0; tick();
        press(1);
        chk("repress_valid", int'(evt_valid), 1);
        chk("repress_id", int'(evt_id), 1);
        ready = 1'b1; repeat (3) tick();

`ifdef BUTTON_LONGPRESS_EN
        // Long press on button 1
        do_reset(); ready = 1'b1; popped.delete();
        btn[1] = 1'b1; repeat (40) tick();
        btn[1] = 1'b0; repeat (3) tick();
        chk_popped("long", '{1, 257});
        ready = 1'b0;
        btn[1] = 1'b1; repeat (10) tick();
        reset = 1'b1; tick();
        chk("long_rst_valid", int'(evt_valid), 0);
        tick(); reset = 1'b0; btn = '0; tick();
`endif

        // Randomized traffic
        do_reset(); popped.delete();
        for (int c = 0; c < 4000; c++) begin
            int slow;
            slow = (c / 500) % 2;
            for (int i = 0; i < N; i++)
                if ($urandom_range(slow != 0 ? 60 : 5, 0) == 0) btn[i] = ~btn[i];
            ready = ((c / 300) % 3 == 1) ? 1'b0 : ($urandom_range(3, 0) != 0);
            clr   = ($urandom_range(15, 0) == 0);
            reset = ($urandom_range(599, 0) == 0);
            tick();
        end
        reset = 1'b0; clr = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
